// File: rtl/fft_stage_seq.sv
// fft_stage_seq: sequencing controller for one single-delay-feedback FFT butterfly stage.
// Optional macro FFT_STAGE_SEQ_OVERRUN_CHK_EN: ignore overrun alert_in and raise a sticky err.
module fft_stage_seq #(
    parameter int FRAME_LEN = 4,
    parameter int BF_LAT    = 1,
    parameter int MUL_LAT   = 2,
    parameter int TW_W      = ($clog2(FRAME_LEN / 2) < 1) ? 1 : $clog2(FRAME_LEN / 2)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alert_in,
    output logic            mux_sel,
    output logic            bf_en,
    output logic            mul_en,
    output logic [TW_W-1:0] tw_idx,
    output logic            alert_out,
    output logic            busy,
    output logic            err
);

    localparam int HALF  = FRAME_LEN / 2;
    localparam int CNT_W = $clog2(FRAME_LEN);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [TW_W-1:0]  TW_LAST   = TW_W'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               prev;
    logic [BF_LAT-1:0]  bf_pipe;
    logic [MUL_LAT-1:0] al_pipe;
    logic               mul_en_d;
    logic [TW_W-1:0]    tw_last;
    logic               mul_rise;

`ifdef FFT_STAGE_SEQ_OVERRUN_CHK_EN
    logic err_q;
`endif

    // prev marks a frame that follows another directly; its first half drains the previous frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            prev  <= 1'b0;
`ifdef FFT_STAGE_SEQ_OVERRUN_CHK_EN
            err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (alert_in) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (alert_in) begin
                            prev <= 1'b1;
                        end else begin
                            state <= FLUSH;
                        end
                    end else if (alert_in) begin
`ifdef FFT_STAGE_SEQ_OVERRUN_CHK_EN
                        err_q <= 1'b1;
                        cnt   <= cnt + 1'b1;
`else
                        cnt   <= '0;
                        prev  <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    if (alert_in) begin
                        state <= RUN;
                        cnt   <= '0;
                        prev  <= 1'b1;
                    end else if (cnt == HALF_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        prev  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    prev  <= 1'b0;
                end
            endcase
        end
    end

    assign bf_en   = (state == RUN) && (cnt >= CNT_HALF);
    assign mux_sel = (state == FLUSH) || ((state == RUN) && (cnt < CNT_HALF) && prev);

    assign mul_en   = bf_pipe[BF_LAT-1];
    assign mul_rise = mul_en && !mul_en_d;

    // Twiddle index restarts at each new mul_en run and holds between runs.
    always_comb begin
        tw_idx = tw_last;
        if (mul_en) begin
            if (!mul_en_d || (tw_last == TW_LAST)) begin
                tw_idx = '0;
            end else begin
                tw_idx = tw_last + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bf_pipe  <= '0;
            al_pipe  <= '0;
            mul_en_d <= 1'b0;
            tw_last  <= '0;
        end else begin
            bf_pipe[0] <= bf_en;
            for (int i = 1; i < BF_LAT; i++) begin
                bf_pipe[i] <= bf_pipe[i-1];
            end
            al_pipe[0] <= mul_rise;
            for (int i = 1; i < MUL_LAT; i++) begin
                al_pipe[i] <= al_pipe[i-1];
            end
            mul_en_d <= mul_en;
            tw_last  <= tw_idx;
        end
    end

    assign alert_out = al_pipe[MUL_LAT-1];
    assign busy      = (state != IDLE) || (|bf_pipe) || (|al_pipe);

`ifdef FFT_STAGE_SEQ_OVERRUN_CHK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stage_seq.sv
// tb_fft_stage_seq: checks a default and a FRAME_LEN=8/BF_LAT=2/MUL_LAT=3 instance against
// a cycle-indexed history model, plus hand-computed output masks per directed scenario.
module tb_fft_stage_seq;

    logic clk = 1'b0;
    logic rst;
    logic alert_in;

    logic       mux_sel0, bf_en0, mul_en0, alert_out0, busy0, err0;
    logic [0:0] tw_idx0;
    logic       mux_sel1, bf_en1, mul_en1, alert_out1, busy1, err1;
    logic [1:0] tw_idx1;

    int checks = 0;
    int errors = 0;
    int t = 0;
    int test_base = -100;

    int mode [2];
    int pos [2];
    int prev_m [2];
    int err_m [2];
    int run_len [2];
    int tw_m [2];
    bit bf_h [2][2048];

    logic [31:0] cap_bf [2];
    logic [31:0] cap_mul [2];
    logic [31:0] cap_mux [2];
    logic [31:0] cap_al [2];
    logic [31:0] cap_busy [2];
    logic [31:0] cap_err [2];
    int          cap_tw [2][32];

    fft_stage_seq dut0 (
        .clk(clk), .rst(rst), .alert_in(alert_in),
        .mux_sel(mux_sel0), .bf_en(bf_en0), .mul_en(mul_en0), .tw_idx(tw_idx0),
        .alert_out(alert_out0), .busy(busy0), .err(err0)
    );

    fft_stage_seq #(.FRAME_LEN(8), .BF_LAT(2), .MUL_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .alert_in(alert_in),
        .mux_sel(mux_sel1), .bf_en(bf_en1), .mul_en(mul_en1), .tw_idx(tw_idx1),
        .alert_out(alert_out1), .busy(busy1), .err(err1)
    );

    always #5 clk = ~clk;

    function automatic int p_fl(int d);
        return (d == 0) ? 4 : 8;
    endfunction

    function automatic int p_bl(int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int p_ml(int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic bit hist(int d, int i);
        if (i < 0 || i >= 2048) return 1'b0;
        return bf_h[d][i];
    endfunction

    function automatic bit mul_at(int d, int s);
        return hist(d, s - p_bl(d));
    endfunction

    function automatic bit rise_at(int d, int s);
        return mul_at(d, s) && !mul_at(d, s - 1);
    endfunction

    task automatic cmp(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, t, act, exp);
        end
    endtask

    // Frame-level rules: modes 0=idle 1=run 2=flush, pos = position in current frame/flush.
    task automatic model_step(input int d, input logic r, input logic a);
        int fl;
        int half;
        fl   = p_fl(d);
        half = fl / 2;
        if (r) begin
            mode[d] = 0; pos[d] = 0; prev_m[d] = 0; err_m[d] = 0;
            run_len[d] = 0; tw_m[d] = 0;
            for (int i = 0; i <= t && i < 2048; i++) bf_h[d][i] = 1'b0;
        end else if (mode[d] == 0) begin
            if (a) begin mode[d] = 1; pos[d] = 0; end
        end else if (mode[d] == 1) begin
            if (pos[d] == fl - 1) begin
                pos[d] = 0;
                if (a) prev_m[d] = 1;
                else mode[d] = 2;
            end else if (a) begin
`ifdef FFT_STAGE_SEQ_OVERRUN_CHK_EN
                err_m[d] = 1;
                pos[d] = pos[d] + 1;
`else
                pos[d] = 0;
                prev_m[d] = 1;
`endif
            end else begin
                pos[d] = pos[d] + 1;
            end
        end else begin
            if (a) begin
                mode[d] = 1; pos[d] = 0; prev_m[d] = 1;
            end else if (pos[d] == half - 1) begin
                mode[d] = 0; pos[d] = 0; prev_m[d] = 0;
            end else begin
                pos[d] = pos[d] + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        int rel;
        rel = t - test_base;
        if (rel == 0) begin
            for (int d = 0; d < 2; d++) begin
                cap_bf[d] = '0; cap_mul[d] = '0; cap_mux[d] = '0;
                cap_al[d] = '0; cap_busy[d] = '0; cap_err[d] = '0;
            end
        end
        for (int d = 0; d < 2; d++) begin
            int half;
            bit e_bf, e_mux, e_mul, e_al, e_busy;
            logic a_bf, a_mux, a_mul, a_al, a_busy, a_err;
            int a_tw;
            half  = p_fl(d) / 2;
            e_bf  = (mode[d] == 1) && (pos[d] >= half);
            e_mux = (mode[d] == 2) || ((mode[d] == 1) && (pos[d] < half) && (prev_m[d] != 0));
            bf_h[d][t] = e_bf;
            e_mul = mul_at(d, t);
            if (e_mul) begin
                run_len[d] = mul_at(d, t - 1) ? run_len[d] + 1 : 0;
                tw_m[d] = run_len[d] % half;
            end
            e_al   = rise_at(d, t - p_ml(d));
            e_busy = (mode[d] != 0);
            for (int k = 1; k <= p_bl(d); k++) e_busy = e_busy || hist(d, t - k);
            for (int k = 1; k <= p_ml(d); k++) e_busy = e_busy || rise_at(d, t - k);
            a_bf   = (d == 0) ? bf_en0 : bf_en1;
            a_mux  = (d == 0) ? mux_sel0 : mux_sel1;
            a_mul  = (d == 0) ? mul_en0 : mul_en1;
            a_al   = (d == 0) ? alert_out0 : alert_out1;
            a_busy = (d == 0) ? busy0 : busy1;
            a_err  = (d == 0) ? err0 : err1;
            a_tw   = (d == 0) ? int'(tw_idx0) : int'(tw_idx1);
            cmp("bf_en", d, int'(a_bf), int'(e_bf));
            cmp("mux_sel", d, int'(a_mux), int'(e_mux));
            cmp("mul_en", d, int'(a_mul), int'(e_mul));
            cmp("tw_idx", d, a_tw, tw_m[d]);
            cmp("alert_out", d, int'(a_al), int'(e_al));
            cmp("busy", d, int'(a_busy), int'(e_busy));
            cmp("err", d, int'(a_err), err_m[d]);
            if (rel >= 0 && rel < 32) begin
                cap_bf[d][rel]   = a_bf;
                cap_mux[d][rel]  = a_mux;
                cap_mul[d][rel]  = a_mul;
                cap_al[d][rel]   = a_al;
                cap_busy[d][rel] = a_busy;
                cap_err[d][rel]  = a_err;
                cap_tw[d][rel]   = a_tw;
            end
            model_step(d, rst, alert_in);
        end
        t++;
    end

    task automatic applyStimulus(input logic [31:0] ain_m, input logic [31:0] rst_m, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) test_base = t;
            alert_in = ain_m[c];
            rst      = rst_m[c];
        end
        @(posedge clk);
        #1;
        alert_in = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            mode[d] = 0; pos[d] = 0; prev_m[d] = 0; err_m[d] = 0;
            run_len[d] = 0; tw_m[d] = 0;
        end
        rst      = 1'b1;
        alert_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] single frame and parameter sweep");
        applyStimulus(32'h1, 32'h0, 24);
        checkOutput("single bf_en", cap_bf[0], 32'h18);
        checkOutput("single mul_en", cap_mul[0], 32'h30);
        checkOutput("single mux_sel", cap_mux[0], 32'h60);
        checkOutput("single alert_out", cap_al[0], 32'h40);
        checkOutput("single busy", cap_busy[0], 32'h7E);
        checkOutput("single tw4", 32'(cap_tw[0][4]), 32'd0);
        checkOutput("single tw5", 32'(cap_tw[0][5]), 32'd1);
        checkOutput("sweep bf_en", cap_bf[1], 32'h1E0);
        checkOutput("sweep mul_en", cap_mul[1], 32'h780);
        checkOutput("sweep mux_sel", cap_mux[1], 32'h1E00);
        checkOutput("sweep alert_out", cap_al[1], 32'h400);
        checkOutput("sweep busy", cap_busy[1], 32'h1FFE);
        for (int i = 0; i < 4; i++) checkOutput("sweep tw", 32'(cap_tw[1][7 + i]), 32'(i));

        $display("[TB] back-to-back frames");
        applyStimulus(32'h11, 32'h0, 24);
        checkOutput("b2b bf_en", cap_bf[0], 32'h198);
        checkOutput("b2b mul_en", cap_mul[0], 32'h330);
        checkOutput("b2b mux_sel", cap_mux[0], 32'h660);
        checkOutput("b2b alert_out", cap_al[0], 32'h440);
        checkOutput("b2b busy", cap_busy[0], 32'h7FE);
        checkOutput("b2b tw8", 32'(cap_tw[0][8]), 32'd0);

        $display("[TB] overrun");
        applyStimulus(32'h5, 32'h0, 24);
`ifdef FFT_STAGE_SEQ_OVERRUN_CHK_EN
        checkOutput("overrun bf_en", cap_bf[0], 32'h18);
        checkOutput("overrun mux_sel", cap_mux[0], 32'h60);
        checkOutput("overrun alert_out", cap_al[0], 32'h40);
        checkOutput("overrun err", cap_err[0], 32'h00FF_FFF8);
`else
        checkOutput("overrun bf_en", cap_bf[0], 32'h60);
        checkOutput("overrun mux_sel", cap_mux[0], 32'h198);
        checkOutput("overrun alert_out", cap_al[0], 32'h100);
        checkOutput("overrun err", cap_err[0], 32'h0);
`endif

        $display("[TB] reset mid-frame");
        applyStimulus(32'h41, 32'h8, 24);
        checkOutput("reset bf_en", cap_bf[0], 32'h608);
        checkOutput("reset mul_en", cap_mul[0], 32'hC00);
        checkOutput("reset alert_out", cap_al[0], 32'h1000);
        checkOutput("reset busy", cap_busy[0], 32'h1F8E);
`ifdef FFT_STAGE_SEQ_OVERRUN_CHK_EN
        checkOutput("reset err", cap_err[0], 32'hF);
`else
        checkOutput("reset err", cap_err[0], 32'h0);
`endif

        $display("[TB] restart during flush");
        applyStimulus(32'h21, 32'h0, 24);
        checkOutput("flush restart mux_sel", cap_mux[0], 32'hCE0);
        checkOutput("flush restart alert_out", cap_al[0], 32'h840);
        checkOutput("flush restart mul_en", cap_mul[0], 32'h630);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_stage_seq.md
Name: fft_stage_seq

Overview:
- Sequencing controller for one single-delay-feedback FFT butterfly stage: input delay line, 32-to-16 mux, BF2I butterfly, twiddle multiplier.
- Triggered by the upstream stage's frame-start pulse.
- Generates the per-cycle mux select, butterfly enable, multiplier enable and twiddle index, and emits a frame-start pulse to the next stage.
- Supports back-to-back frames and detects frame overrun.

Parameters:
- FRAME_LEN, 4: cycles per frame (16-lane blocks per frame); power of two, >=2. HALF = FRAME_LEN/2.
- BF_LAT, 1: butterfly register latency in cycles; >=1.
- MUL_LAT, 2: twiddle multiplier latency in cycles; >=1.
- TW_W, $clog2(HALF) (min 1): twiddle index width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alert_in  in  1  frame-start pulse from the upstream stage.
- mux_sel  out  1  0 = direct add-path to the delay line, 1 = delayed sub-path (drain).
- bf_en  out  1  butterfly enable.
- mul_en  out  1  twiddle multiplier enable.
- tw_idx  out  TW_W  twiddle select for the current mul_en cycle.
- alert_out  out  1  frame-start pulse to the next stage.
- busy  out  1  frame in flight or pipeline not yet empty.
- err  out  1  sticky overrun flag.

Behaviour:
- Reset: clk and a single synchronous active-high reset; rst sampled only on the rising clk edge.
  - Reset clears all state: state=IDLE, cnt=0, prev=0, all delay pipes cleared.
  - All outputs are 0 in the cycle after rst is sampled high. alert_in is ignored while rst=1.
  - rst mid-frame aborts the frame: no alert_out is emitted for it; err is cleared.
- States: IDLE, RUN, FLUSH. Counter cnt is $clog2(FRAME_LEN) bits.
- IDLE: alert_in=1 -> RUN, cnt=0.
- RUN: cnt increments each cycle.
  - At cnt=FRAME_LEN-1 with alert_in=1 -> stay in RUN, cnt=0, prev=1 (back-to-back frame).
  - At cnt=FRAME_LEN-1 with alert_in=0 -> FLUSH, cnt=0.
- FLUSH: lasts HALF cycles, then -> IDLE, prev=0.
  - alert_in=1 during FLUSH: starts a new frame (-> RUN, cnt=0, prev=1). The remaining flush cycles are covered by the new frame's first half.
- Overrun: alert_in=1 in RUN with cnt!=FRAME_LEN-1.
- Output decode (Moore, from registered state/cnt):
  - bf_en = RUN and cnt>=HALF.
  - mux_sel = FLUSH, or (RUN and cnt<HALF and prev).
- Pipelined outputs:
  - mul_en = bf_en delayed BF_LAT cycles (shift register).
  - tw_idx: 0 on the first mul_en cycle of each run, +1 on each subsequent consecutive mul_en cycle, wraps mod HALF. Held at its last value when mul_en=0.
  - alert_out: single-cycle pulse MUL_LAT cycles after each rising edge of mul_en (the first valid multiplier output of a frame). For back-to-back frames, mul_en falls between frames, so each frame produces exactly one alert_out.
- busy = (state!=IDLE) or any bit set in the mul_en/alert_out delay pipes.
- Latency from alert_in (cycle 0, defaults):
  - RUN cycles 1..4, bf_en cycles 3..4.
  - mul_en cycles 4..5, tw_idx 0,1.
  - FLUSH and mux_sel cycles 5..6.
  - alert_out cycle 6.
  - IDLE from cycle 7; busy cycles 1..6.

Optional Feature:
- Macro: FFT_STAGE_SEQ_OVERRUN_CHK_EN.
- Defined: an overrun alert_in is ignored (timing unchanged), and err is set the next cycle and held until rst.
- Undefined: an overrun alert_in restarts the frame (cnt=0, prev=1, stay in RUN). err is tied to 0.

Test Plan:
- Single frame, defaults, alert_in at cycle 0 -> bf_en at 3,4; mul_en at 4,5 with tw_idx 0,1; mux_sel at 5,6; alert_out only at 6; busy 1..6; IDLE at 7.
- Back-to-back, alert_in at cycles 0 and 4 -> RUN continues, cnt=0 at cycle 5; mux_sel at 5,6; bf_en at 3,4,7,8; mul_en at 4,5,8,9; alert_out at 6 and 10; mux_sel at 9,10; IDLE at 11.
- Overrun, alert_in at cycles 0 and 2:
  - Macro defined -> err=1 from cycle 3 and stays 1; outputs identical to the single-frame case.
  - Macro undefined -> cnt=0 at cycle 3, err=0.
- Reset mid-frame, rst=1 at cycle 3 -> bf_en, mul_en, alert_out, busy and err all 0 from cycle 4; no alert_out ever emitted for that frame; a new alert_in at cycle 6 gives alert_out at cycle 12.
- Parameter sweep, FRAME_LEN=8, BF_LAT=2, MUL_LAT=3, alert_in at cycle 0 -> bf_en at 5..8; mul_en at 7..10 with tw_idx 0,1,2,3; mux_sel at 9..12; alert_out at cycle 10.
